// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480@60 timing, phase state types, and the colour /
// cell geometry used by the display stage.
package vga_pkg;

  localparam int CNT_W = 10;

  // Horizontal timing in pixels, vertical timing in lines.
  localparam int H_ACTIVE_LEN = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC_LEN   = 96;
  localparam int H_BP         = 48;
  localparam int V_ACTIVE_LEN = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC_LEN   = 2;
  localparam int V_BP         = 33;

  typedef enum logic [1:0] {
    H_ACTIVE = 2'd0,
    H_FRONT  = 2'd1,
    H_SYNC   = 2'd2,
    H_BACK   = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    V_ACTIVE = 2'd0,
    V_FRONT  = 2'd1,
    V_SYNC   = 2'd2,
    V_BACK   = 2'd3
  } v_state_t;

  // 4:4:4 RGB colour and the board-cell grid drawn by the display stage.
  localparam int COLOR_W = 12;
  typedef logic [COLOR_W-1:0] rgb_t;
  localparam rgb_t COL_BLACK = 12'h000;
  localparam rgb_t COL_WHITE = 12'hFFF;
  localparam rgb_t COL_GRID  = 12'h444;
  localparam rgb_t COL_BG    = 12'h013;

  localparam int CELL_PX   = 32;
  localparam int GRID_COLS = H_ACTIVE_LEN / CELL_PX;
  localparam int GRID_ROWS = V_ACTIVE_LEN / CELL_PX;

endpackage

// File: rtl/tick_gen.sv
// Pixel-rate enable: divides clk by 4, p_tick is high for the one clk where
// the divider reads 3.
module tick_gen (
  input  logic clk,
  input  logic reset_n,
  output logic p_tick
);

  logic [1:0] div_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_q <= 2'd0;
    else          div_q <= div_q + 2'd1;
  end

  assign p_tick = (div_q == 2'd3);

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: pixel/line counters, horizontal and vertical phase FSMs,
// registered syncs/blanking aligned with x,y, and frame/vblank strobes.
module vga_sync
  import vga_pkg::*;
#(
  parameter int P_H_ACT  = H_ACTIVE_LEN,
  parameter int P_H_FP   = H_FP,
  parameter int P_H_SYNC = H_SYNC_LEN,
  parameter int P_H_BP   = H_BP,
  parameter int P_V_ACT  = V_ACTIVE_LEN,
  parameter int P_V_FP   = V_FP,
  parameter int P_V_SYNC = V_SYNC_LEN,
  parameter int P_V_BP   = V_BP
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             videoOn,
  output logic             hsync,
  output logic             vsync,
  output logic             p_tick,
  output logic             frame_start,
  output logic             vblank_start,
  output h_state_t         dbg_h_state,
  output v_state_t         dbg_v_state
);

  // Last count of each phase; a phase FSM leaves its state on the tick at that count.
  localparam logic [CNT_W-1:0] H_ACT_LAST  = CNT_W'(P_H_ACT - 1);
  localparam logic [CNT_W-1:0] H_FP_LAST   = CNT_W'(P_H_ACT + P_H_FP - 1);
  localparam logic [CNT_W-1:0] H_SYNC_LAST = CNT_W'(P_H_ACT + P_H_FP + P_H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(P_H_ACT + P_H_FP + P_H_SYNC + P_H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST  = CNT_W'(P_V_ACT - 1);
  localparam logic [CNT_W-1:0] V_FP_LAST   = CNT_W'(P_V_ACT + P_V_FP - 1);
  localparam logic [CNT_W-1:0] V_SYNC_LAST = CNT_W'(P_V_ACT + P_V_FP + P_V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(P_V_ACT + P_V_FP + P_V_SYNC + P_V_BP - 1);

  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  h_state_t         h_q, h_d;
  v_state_t         v_q, v_d;
  logic             x_wrap, y_wrap, line_end;

  tick_gen u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .p_tick  (p_tick)
  );

  assign x_wrap   = (x_q == H_LAST);
  assign y_wrap   = (y_q == V_LAST);
  assign line_end = p_tick && x_wrap;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (p_tick) x_d = x_wrap ? '0 : x_q + CNT_W'(1);
    if (line_end) y_d = y_wrap ? '0 : y_q + CNT_W'(1);
  end

  always_comb begin
    h_d = h_q;
    if (p_tick) begin
      case (h_q)
        H_ACTIVE: if (x_q == H_ACT_LAST)  h_d = H_FRONT;
        H_FRONT:  if (x_q == H_FP_LAST)   h_d = H_SYNC;
        H_SYNC:   if (x_q == H_SYNC_LAST) h_d = H_BACK;
        H_BACK:   if (x_q == H_LAST)      h_d = H_ACTIVE;
        default:                          h_d = H_ACTIVE;
      endcase
    end
  end

  always_comb begin
    v_d = v_q;
    if (line_end) begin
      case (v_q)
        V_ACTIVE: if (y_q == V_ACT_LAST)  v_d = V_FRONT;
        V_FRONT:  if (y_q == V_FP_LAST)   v_d = V_SYNC;
        V_SYNC:   if (y_q == V_SYNC_LAST) v_d = V_BACK;
        V_BACK:   if (y_q == V_LAST)      v_d = V_ACTIVE;
        default:                          v_d = V_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
      h_q <= H_ACTIVE;
      v_q <= V_ACTIVE;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Outputs are decoded from next state so they change on the same edge as x,y.
  // videoOn resets low so the post-reset pixel (0,0) stays blanked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      videoOn      <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      frame_start  <= line_end && y_wrap;
      vblank_start <= line_end && (y_q == V_ACT_LAST);
      if (p_tick) begin
        hsync   <= (h_d != H_SYNC);
        vsync   <= (v_d != V_SYNC);
        videoOn <= (h_d == H_ACTIVE) && (v_d == V_ACTIVE);
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign dbg_h_state = h_q;
  assign dbg_v_state = v_q;

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL have port clk  input  1  system clock, 100 MHz; all state on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port x  output  10  current horizontal pixel count, 0..799.
REQ-004 SHALL have port y  output  10  current vertical line count, 0..524.
REQ-005 SHALL have port videoOn  output  1  high while (x,y) is in the 640x480 visible region.
REQ-006 SHALL have port hsync  output  1  horizontal sync, active-low.
REQ-007 SHALL have port vsync  output  1  vertical sync, active-low.
REQ-008 SHALL have port p_tick  output  1  one-clk pulse per pixel period, 25 MHz rate.
REQ-009 SHALL have port frame_start  output  1  one-clk pulse when counters wrap to (0,0).
REQ-010 SHALL have port vblank_start  output  1  one-clk pulse when y advances to 480; this is the safe instant for board-colour updates to the display stage.

Function
REQ-011 SHALL divide clk by 4 with a 2-bit counter; p_tick is high for exactly one clk when the divider equals 3.
REQ-012 Counters SHALL advance only on clk edges where p_tick is high.
REQ-013 x SHALL increment by 1 per p_tick and wrap from 799 to 0.
REQ-014 y SHALL increment by 1 only on the p_tick where x wraps, and SHALL wrap from 524 to 0.
REQ-015 Horizontal timing SHALL be: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-016 Vertical timing SHALL be: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-017 Horizontal phase FSM SHALL have states H_ACTIVE, H_FRONT, H_SYNC, H_BACK and advance on the p_tick where x reaches each phase's last count. The vertical FSM V_ACTIVE, V_FRONT, V_SYNC, V_BACK SHALL work the same way on line wraps.
REQ-018 hsync SHALL be 0 only in H_SYNC; vsync SHALL be 0 only in V_SYNC.
REQ-019 videoOn SHALL be 1 only when both FSMs are in their ACTIVE state.
REQ-020 hsync, vsync and videoOn SHALL be registered and cycle-aligned with x and y; there is no pipeline offset between them.
REQ-021 frame_start SHALL pulse on the same clk edge at which (x,y) becomes (0,0) from (799,524).
REQ-022 vblank_start SHALL pulse on the same clk edge at which y becomes 480.
REQ-023 Between p_ticks, all outputs except p_tick SHALL hold their values.
REQ-024 One frame SHALL take exactly 800*525*4 = 1,680,000 clk cycles.

Reset
REQ-025 While reset_n = 0, the block SHALL hold: divider=0, x=0, y=0, H_ACTIVE, V_ACTIVE, hsync=1, vsync=1, videoOn=0, p_tick=0, frame_start=0, vblank_start=0.
REQ-026 Asserting reset_n mid-frame SHALL clear all state immediately, independent of clk.
REQ-027 After deassertion, videoOn SHALL become 1 on the first p_tick edge, with x=1 and y=0. Pixel (0,0) of the first frame is blanked.
REQ-028 No frame_start SHALL be generated for the post-reset (0,0).

Structure
REQ-029 A shared package vga_pkg SHALL hold H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33, and the H/V phase state enumerations.
REQ-030 The same package SHALL hold the 12-bit colour and cell-geometry constants shared with the display stage.
REQ-031 The pixel-tick divider SHALL be a sub-module named tick_gen (clk, reset_n, p_tick).

Verification
REQ-032 Reset release, then count p_ticks: the gap between pulses is exactly 4 clk, and x=1 on the first tick.
REQ-033 Run one full line: hsync is low for exactly 96 p_ticks, with the first low at x=656 and high again at x=752.
REQ-034 Run to x=799, y=524, then one more p_tick: x=0, y=0, frame_start=1 for 1 clk, vsync=1.
REQ-035 Run a full frame: vsync is low for 2*800 p_ticks starting at y=490; vblank_start pulses once, at y=480, x=0.
REQ-036 Sample videoOn across a frame: 1 exactly 640*480 = 307,200 times per frame, at the p_tick sample points.
REQ-037 Assert reset_n=0 at x=300, y=200 between clk edges: all outputs take their reset values immediately; after release, timing restarts per REQ-027.
